// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR decrypt engine: FSM state encoding,
// LFSR width, the preamble character and the LFSR next-state function.
package lfsr_pkg;

  localparam int         LFSR_W     = 7;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    LOAD_TAP,
    CHECK,
    DEC_RD,
    DEC_WR,
    DONE,
    FAIL
  } state_e;

  // Shift left by one and feed the parity of the tapped bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state,
                                                  input logic [LFSR_W-1:0] tap);
    return {state[LFSR_W-2:0], ^(state & tap)};
  endfunction

endpackage

// File: rtl/lfsr_decrypt_engine_if.sv
// Data-memory bus driven by the decrypt engine: combinational read,
// synchronous write, one shared address.
interface lfsr_decrypt_engine_if;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  modport master (output MemAddr, MemWrEn, MemWrData, input MemRdData);
  modport slave  (input MemAddr, MemWrEn, MemWrData, output MemRdData);
endinterface

// File: rtl/lfsr_decrypt_engine_lfsr7_step.sv
// Combinational 7-bit LFSR next-state generator; kept separate so an
// encrypt engine can reuse the same keystream definition.
module lfsr7_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  input  logic [LFSR_W-1:0] tap,
  output logic [LFSR_W-1:0] state_next
);

  assign state_next = lfsr_next(state, tap);

endmodule

// File: rtl/lfsr_decrypt_engine.sv
// LFSR decrypt engine: recovers the seed from a space preamble, searches the
// tap list for the first tap that reproduces the preamble, then writes the
// plaintext back at two cycles per byte.
// Optional feature macro: PARITY_CHECK_EN (bit 7 of each encrypted byte
// carries even parity over bits 6:0; bad bytes are flagged and set Error).
module lfsr_decrypt_engine
  import lfsr_pkg::*;
#(
  parameter logic [7:0] MSG_BASE = 8'd0,
  parameter logic [7:0] ENC_BASE = 8'd64,
  parameter int         MSG_LEN  = 64,
  parameter logic [7:0] TAP_BASE = 8'd130,
  parameter int         NUM_TAPS = 9,
  parameter int         PRE_LEN  = 4,
  parameter logic [7:0] SPACE    = SPACE_CHAR
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Error,
  output logic [3:0]                  TapIdx,
  lfsr_decrypt_engine_if.master       mem
);

`ifdef PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
  localparam logic [7:0] MSG_LAST = 8'(MSG_LEN - 1);
  localparam logic [3:0] TAP_LAST = 4'(NUM_TAPS - 1);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   seed_q, s_q, tap_q;
  logic [3:0]          t_q, tap_idx_q;
  logic [7:0]          k_q, d_q;
  logic                error_q;

  logic [LFSR_W-1:0]   rd7;
  logic                parity_ok;
  logic                pre_match;
  logic [LFSR_W-1:0]   step_in, step_tap, step_out;
  logic [7:0]          addr;
  logic                wr_en;
  logic [7:0]          wr_data;

  assign rd7       = mem.MemRdData[LFSR_W-1:0];
  assign parity_ok = !PARITY_EN || (mem.MemRdData[7] == ^rd7);
  assign pre_match = parity_ok && ((rd7 ^ s_q) == SPACE[LFSR_W-1:0]);

  // While loading a tap the first step starts from the seed with the tap
  // still on the read bus; every other step advances the running state.
  assign step_in  = (state_q == LOAD_TAP) ? seed_q : s_q;
  assign step_tap = (state_q == LOAD_TAP) ? rd7    : tap_q;

  lfsr7_step u_step (
    .state      (step_in),
    .tap        (step_tap),
    .state_next (step_out)
  );

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and memory bus drive.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    addr    = 8'd0;
    wr_en   = 1'b0;
    wr_data = 8'd0;
    unique case (state_q)
      IDLE:     if (Start) state_d = SEED;
      SEED: begin
        addr    = ENC_BASE;
        state_d = LOAD_TAP;
      end
      LOAD_TAP: begin
        addr    = TAP_BASE + {4'd0, t_q};
        state_d = CHECK;
      end
      CHECK: begin
        addr = ENC_BASE + k_q;
        if (pre_match) begin
          if (k_q == PRE_LAST) state_d = DEC_RD;
        end else if (t_q == TAP_LAST) begin
          state_d = FAIL;
        end else begin
          state_d = LOAD_TAP;
        end
      end
      DEC_RD: begin
        addr    = ENC_BASE + k_q;
        state_d = DEC_WR;
      end
      DEC_WR: begin
        addr    = MSG_BASE + k_q;
        wr_en   = 1'b1;
        wr_data = d_q;
        state_d = (k_q == MSG_LAST) ? DONE : DEC_RD;
      end
      DONE:     state_d = IDLE;
      FAIL:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Seed, tap search, keystream and byte counters advanced per state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      seed_q    <= '0;
      s_q       <= '0;
      tap_q     <= '0;
      t_q       <= '0;
      k_q       <= '0;
      d_q       <= '0;
      error_q   <= 1'b0;
      tap_idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:     if (Start) error_q <= 1'b0;
        SEED: begin
          seed_q <= rd7 ^ SPACE[LFSR_W-1:0];
          t_q    <= '0;
        end
        LOAD_TAP: begin
          tap_q <= rd7;
          s_q   <= step_out;
          k_q   <= 8'd1;
        end
        CHECK: begin
          if (pre_match) begin
            if (k_q == PRE_LAST) begin
              s_q <= seed_q;
              k_q <= 8'd0;
            end else begin
              s_q <= step_out;
              k_q <= k_q + 8'd1;
            end
          end else if (t_q == TAP_LAST) begin
            error_q <= 1'b1;
          end else begin
            t_q <= t_q + 4'd1;
          end
        end
        DEC_RD: begin
          d_q <= {~parity_ok, rd7 ^ s_q};
          if (!parity_ok) error_q <= 1'b1;
        end
        DEC_WR: begin
          s_q <= step_out;
          if (k_q == MSG_LAST) tap_idx_q <= t_q;
          else                 k_q       <= k_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign Busy          = (state_q != IDLE);
  assign Done          = (state_q == DONE);
  assign Error         = error_q;
  assign TapIdx        = tap_idx_q;
  assign mem.MemAddr   = addr;
  assign mem.MemWrEn   = wr_en;
  assign mem.MemWrData = wr_data;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Scoreboard bench for lfsr_decrypt_engine: the stimulus side builds each
// encrypted job, predicts the outcome with a keystream model and queues it;
// a monitor compares when the engine drops Busy.
module tb_lfsr_decrypt_engine;

  localparam int MSG_LEN  = 64;
  localparam int NUM_TAPS = 9;
  localparam int PRE_LEN  = 4;
  localparam int MSG_BASE = 0;
  localparam int ENC_BASE = 64;
  localparam int TAP_BASE = 130;
  localparam logic [7:0] SENT = 8'hEE;

`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    bit         exp_done;
    bit         exp_err;
    logic [3:0] exp_tap;
    int         exp_cycles;   // -1: not checked
    int         exp_writes;   // -1: not checked
    logic [7:0] exp_msg [MSG_LEN];
    bit         chk     [MSG_LEN];
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic       Busy, Done, Error;
  logic [3:0] TapIdx;

  lfsr_decrypt_engine_if bus ();

  lfsr_decrypt_engine dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Busy   (Busy),
    .Done   (Done),
    .Error  (Error),
    .TapIdx (TapIdx),
    .mem    (bus)
  );

  always #5 Clk = ~Clk;

  logic [7:0] ram [256];
  assign bus.MemRdData = ram[bus.MemAddr];
  always @(posedge Clk) if (bus.MemWrEn) ram[bus.MemAddr] = bus.MemWrData;

  int total = 0;
  int bad   = 0;
  exp_t sbq [$];

  logic [7:0] plain_img [MSG_LEN];
  logic [7:0] enc_img   [MSG_LEN];
  logic [6:0] tap_img   [NUM_TAPS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Keystream byte k: start at the seed, each step doubles modulo 128 and
  // adds the parity of the tapped bits.
  function automatic logic [6:0] ks_at(input logic [6:0] seed, input logic [6:0] tap, input int k);
    int v;
    v = int'(seed);
    for (int j = 0; j < k; j++)
      v = ((v * 2) % 128) + ($countones(7'(v) & tap) % 2);
    return 7'(v);
  endfunction

  function automatic bit pbad(input logic [7:0] b);
    return PAR_EN && (b[7] != ^b[6:0]);
  endfunction

  task automatic encrypt(input logic [6:0] seed, input int sel, input bit rand_b7);
    logic [6:0] low;
    logic       b7;
    for (int k = 0; k < MSG_LEN; k++) begin
      low = plain_img[k][6:0] ^ ks_at(seed, tap_img[sel], k);
      if (PAR_EN)       b7 = ^low;
      else if (rand_b7) b7 = 1'($urandom);
      else              b7 = 1'b0;
      enc_img[k] = {b7, low};
    end
  endtask

  task automatic build_expect(output exp_t e);
    logic [6:0] seed;
    int cyc, found, n;
    bit ok;
    seed  = enc_img[0][6:0] ^ 7'h20;
    cyc   = 1;
    found = -1;
    for (int i = 0; i < NUM_TAPS && found < 0; i++) begin
      n  = 0;
      ok = 1'b1;
      for (int k = 1; k < PRE_LEN && ok; k++) begin
        n++;
        if (pbad(enc_img[k]) || ((enc_img[k][6:0] ^ ks_at(seed, tap_img[i], k)) != 7'h20))
          ok = 1'b0;
      end
      cyc += 1 + n;
      if (ok) found = i;
    end
    e.exp_err = 1'b0;
    for (int k = 0; k < MSG_LEN; k++) e.chk[k] = 1'b1;
    if (found >= 0) begin
      e.exp_done   = 1'b1;
      e.exp_tap    = 4'(found);
      e.exp_cycles = cyc + 2 * MSG_LEN + 1;
      e.exp_writes = MSG_LEN;
      for (int k = 0; k < MSG_LEN; k++) begin
        e.exp_msg[k] = {pbad(enc_img[k]), enc_img[k][6:0] ^ ks_at(seed, tap_img[found], k)};
        if (pbad(enc_img[k])) e.exp_err = 1'b1;
      end
    end else begin
      e.exp_done   = 1'b0;
      e.exp_err    = 1'b1;
      e.exp_tap    = 4'd0;
      e.exp_cycles = cyc + 1;
      e.exp_writes = 0;
      for (int k = 0; k < MSG_LEN; k++) e.exp_msg[k] = SENT;
    end
  endtask

  task automatic load_mem();
    for (int k = 0; k < MSG_LEN; k++) begin
      ram[ENC_BASE + k] = enc_img[k];
      ram[MSG_BASE + k] = SENT;
    end
    for (int i = 0; i < NUM_TAPS; i++) ram[TAP_BASE + i] = {1'($urandom), tap_img[i]};
  endtask

  task automatic random_plain();
    for (int k = 0; k < MSG_LEN; k++)
      plain_img[k] = (k < PRE_LEN) ? 8'h20 : 8'($urandom_range(32, 126));
  endtask

  task automatic pulse_start();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
  endtask

  task automatic wait_drain(input bit spam);
    for (int c = 0; c < 2000 && sbq.size() > 0; c++) begin
      @(negedge Clk);
      Start = spam && Busy && ($urandom_range(0, 2) == 0);
    end
    Start = 1'b0;
    check("queue_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic run_job(input bit spam);
    exp_t e;
    load_mem();
    build_expect(e);
    sbq.push_back(e);
    pulse_start();
    wait_drain(spam);
    repeat (2) @(negedge Clk);
  endtask

  task automatic random_job(input bit corrupt);
    logic [6:0] seed;
    int sel;
    seed = 7'($urandom);
    sel  = $urandom_range(0, NUM_TAPS - 1);
    for (int i = 0; i < NUM_TAPS; i++) tap_img[i] = 7'($urandom);
    random_plain();
    encrypt(seed, sel, 1'b1);
    if (corrupt) enc_img[$urandom_range(1, PRE_LEN - 1)] ^= 8'(1 << $urandom_range(0, 6));
    run_job(1'b0);
  endtask

  // Monitor: per-job counters, compared against the queue head when Busy falls.
  int   job_cycles, job_writes, job_oob, job_dones;
  bit   prev_busy = 1'b0;
  exp_t mon_e;

  always @(negedge Clk) begin
    if (!prev_busy && Busy) begin
      job_cycles = 0; job_writes = 0; job_oob = 0; job_dones = 0;
    end
    if (Busy) job_cycles++;
    if (bus.MemWrEn) begin
      job_writes++;
      if (int'(bus.MemAddr) < MSG_BASE || int'(bus.MemAddr) >= MSG_BASE + MSG_LEN) job_oob++;
    end
    if (Done) job_dones++;
    if (prev_busy && !Busy) begin
      if (sbq.size() == 0) begin
        check("unexpected_job_end", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("done_pulses", job_dones, mon_e.exp_done ? 1 : 0);
        check("error", Error, mon_e.exp_err);
        if (mon_e.exp_done)          check("tap_idx", TapIdx, mon_e.exp_tap);
        if (mon_e.exp_cycles >= 0)   check("busy_cycles", job_cycles, mon_e.exp_cycles);
        if (mon_e.exp_writes >= 0)   check("write_count", job_writes, mon_e.exp_writes);
        check("oob_writes", job_oob, 0);
        for (int i = 0; i < MSG_LEN; i++)
          if (mon_e.chk[i]) check($sformatf("mem[%0d]", MSG_BASE + i), ram[MSG_BASE + i], mon_e.exp_msg[i]);
      end
    end
    prev_busy = Busy;
  end

  initial begin
    exp_t  e;
    string txt;
    bit    differ, hit;

    for (int a = 0; a < 256; a++) ram[a] = 8'h00;
    Reset = 1'b1;
    Start = 1'b1;   // Start together with Reset must be ignored
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b0;
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_error", Error, 0);
    check("reset_tapidx", TapIdx, 0);
    check("reset_wren", bus.MemWrEn, 0);
    check("reset_addr", bus.MemAddr, 0);
    repeat (2) @(negedge Clk);
    check("idle_after_reset", Busy, 0);

    // All-space message, seed 0x01, tap 0x60 at index 0.
    for (int i = 0; i < NUM_TAPS; i++) tap_img[i] = 7'($urandom);
    tap_img[0] = 7'h60;
    for (int k = 0; k < MSG_LEN; k++) plain_img[k] = 8'h20;
    encrypt(7'h01, 0, 1'b0);
    run_job(1'b0);

    // Target tap 5 (0x69), seed 0x35; lower taps forced to miss the preamble.
    for (int i = 0; i < NUM_TAPS; i++) tap_img[i] = 7'($urandom);
    tap_img[5] = 7'h69;
    for (int i = 0; i < 5; i++) begin
      differ = 1'b0;
      for (int a = 0; a < 200 && !differ; a++) begin
        tap_img[i] = 7'($urandom);
        for (int k = 1; k < PRE_LEN; k++)
          if (ks_at(7'h35, tap_img[i], k) != ks_at(7'h35, 7'h69, k)) differ = 1'b1;
      end
    end
    random_plain();
    txt = "    HELLO, LFSR WORLD!";
    for (int i = 0; i < txt.len(); i++) plain_img[i] = txt[i];
    encrypt(7'h35, 5, 1'b1);
    run_job(1'b0);

    // Corrupted preamble byte: no tap can match, expect FAIL and no writes.
    enc_img[1] = 8'h00;
    run_job(1'b0);

    // Reset while writing byte 10; then a normal job.
    random_job(1'b0);
    load_mem();
    build_expect(e);
    e.exp_done   = 1'b0;
    e.exp_err    = 1'b0;
    e.exp_cycles = -1;
    e.exp_writes = -1;
    e.chk[10]    = 1'b0;
    for (int k = 11; k < MSG_LEN; k++) e.exp_msg[k] = SENT;
    sbq.push_back(e);
    pulse_start();
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge Clk);
      if (bus.MemWrEn && bus.MemAddr == 8'(MSG_BASE + 10)) hit = 1'b1;
    end
    check("abort_point_reached", hit, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_wren", bus.MemWrEn, 0);
    check("abort_addr_idle", bus.MemAddr, 0);
    check("abort_tapidx", TapIdx, 0);
    wait_drain(1'b0);
    random_job(1'b0);

    // Start hammered while Busy: exactly one Done, no restart afterwards.
    random_plain();
    encrypt(7'($urandom), $urandom_range(0, NUM_TAPS - 1), 1'b1);
    run_job(1'b1);
    repeat (4) @(negedge Clk);
    check("no_restart", Busy, 0);

    // Bit 7 of encrypted byte 20 flipped.
    random_plain();
    encrypt(7'($urandom), $urandom_range(0, NUM_TAPS - 1), 1'b0);
    enc_img[20][7] = ~enc_img[20][7];
    run_job(1'b0);

    // Randomized jobs, some with damaged preambles.
    for (int j = 0; j < 8; j++) random_job(($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
